// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM for the multi-cycle RV32I datapath.
// Supports lw, sw, R-type (add/sub/and/or/slt) and beq.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   op, func3, func7      instruction fields from the instruction register
//   alu_zero, mem_ready   datapath / memory status
//   mem_req, mem_write    memory request strobe and store qualifier
//   adr_src               memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write    IR/OldPC load, PC load
//   reg_write, retire     register write enable, final-cycle pulse
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_ctrl, imm_src     ALU operation, immediate format
//   result_src            result bus select
//   illegal, state        sticky illegal flag, current state code
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_NONE = 3'b111;

    state_t cur, nxt;

    logic is_ld, is_st, is_r, is_beq;
    logic unused_func7;

    assign is_ld  = (op == OP_LW);
    assign is_st  = (op == OP_SW);
    assign is_r   = (op == OP_R);
    assign is_beq = (op == OP_BEQ);

    assign unused_func7 = ^{func7[6], func7[4:0]};

    assign state = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_NONE;
        imm_src    = 2'b00;
        result_src = 2'b00;

        // Reset masks every output; the state register clears on the edge.
        if (!rst) begin
            unique case (cur)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        alu_ctrl   = ALU_ADD;
                        result_src = 2'b10;
                        nxt        = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target OldPC + imm lands in ALUOut.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = 2'b10;
                    alu_ctrl  = ALU_ADD;
                    unique case (1'b1)
                        is_ld, is_st: nxt = S_MEMADR;
                        is_r:         nxt = S_EXECR;
                        is_beq:       nxt = S_BEQ;
                        default:      nxt = S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    imm_src   = is_st ? 2'b01 : 2'b00;
                    nxt       = is_st ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        nxt = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) begin
                        nxt = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b00;
                    nxt       = S_ALUWB;
                    unique case (func3)
                        3'b000:  alu_ctrl = func7[5] ? ALU_SUB : ALU_ADD;
                        3'b111:  alu_ctrl = ALU_AND;
                        3'b110:  alu_ctrl = ALU_OR;
                        3'b010:  alu_ctrl = ALU_SLT;
                        default: nxt      = S_ILLEGAL;
                    endcase
                end
                S_ALUWB: begin
                    result_src = 2'b00;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b00;
                    alu_ctrl   = ALU_SUB;
                    result_src = 2'b00;
                    pc_write   = alu_zero;
                    retire     = 1'b1;
                    nxt        = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                // Unused encodings are treated as a trap.
                default: begin
                    nxt = S_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl.
// Each step drives inputs, checks state, strobes and selects, then clocks.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic       retire;
    logic       illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .result_src (result_src),
        .retire     (retire),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes: {mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal}
    localparam logic [6:0] ST_NONE  = 7'b0000000;
    localparam logic [6:0] ST_REQ   = 7'b1000000;
    localparam logic [6:0] ST_FRDY  = 7'b1011000;
    localparam logic [6:0] ST_WB    = 7'b0000110;
    localparam logic [6:0] ST_WRW   = 7'b1100000;
    localparam logic [6:0] ST_WRRDY = 7'b1100010;
    localparam logic [6:0] ST_BEQT  = 7'b0001010;
    localparam logic [6:0] ST_BEQN  = 7'b0000010;
    localparam logic [6:0] ST_ILL   = 7'b0000001;

    // Selects: {adr_src, alu_src_a, alu_src_b, alu_ctrl, imm_src, result_src}
    localparam logic [11:0] SL_DEF  = {1'b0, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00};
    localparam logic [11:0] SL_FRDY = {1'b0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10};
    localparam logic [11:0] SL_DEC  = {1'b0, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00};
    localparam logic [11:0] SL_ALW  = {1'b0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00};
    localparam logic [11:0] SL_ASW  = {1'b0, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00};
    localparam logic [11:0] SL_MEM  = {1'b1, 2'b00, 2'b00, 3'b111, 2'b00, 2'b00};
    localparam logic [11:0] SL_MWB  = {1'b0, 2'b00, 2'b00, 3'b111, 2'b00, 2'b01};
    localparam logic [11:0] SL_BEQ  = {1'b0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    function automatic logic [11:0] sl_ex(input logic [2:0] c);
        return {1'b0, 2'b10, 2'b00, c, 2'b00, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rdy, input logic zero,
                        input logic [3:0] es, input logic [6:0] estb,
                        input logic [11:0] esel);
        mem_ready = rdy;
        alu_zero  = zero;
        #1;
        chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
        chk({tag, ".strobe"},
            {25'd0, mem_req, mem_write, ir_write, pc_write,
             reg_write, retire, illegal},
            {25'd0, estb});
        chk({tag, ".select"},
            {20'd0, adr_src, alu_src_a, alu_src_b, alu_ctrl,
             imm_src, result_src},
            {20'd0, esel});
        @(posedge clk);
        #1;
    endtask

    logic [2:0] r_f3 [4];
    logic [6:0] r_f7 [4];
    logic [2:0] r_alu[4];

    initial begin
        rst       = 1'b1;
        op        = OP_SW;
        func3     = 3'b000;
        func7     = 7'h00;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        r_f3[0] = 3'b000; r_f7[0] = 7'h20; r_alu[0] = 3'b001;
        r_f3[1] = 3'b111; r_f7[1] = 7'h00; r_alu[1] = 3'b010;
        r_f3[2] = 3'b110; r_f7[2] = 7'h00; r_alu[2] = 3'b011;
        r_f3[3] = 3'b010; r_f7[3] = 7'h00; r_alu[3] = 3'b101;

        @(posedge clk);
        #1;
        step("rst_hold", 1'b1, 1'b0, 4'd0, ST_NONE, SL_DEF);
        rst = 1'b0;

        // sw, zero wait
        step("sw_fwait", 1'b0, 1'b0, 4'd0, ST_REQ, SL_DEF);
        step("sw_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("sw_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
        step("sw_adr", 1'b0, 1'b0, 4'd2, ST_NONE, SL_ASW);
        step("sw_wr", 1'b1, 1'b0, 4'd5, ST_WRRDY, SL_MEM);

        // lw abandoned by reset during the read wait
        op = OP_LW;
        step("rl_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("rl_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
        step("rl_adr", 1'b0, 1'b0, 4'd2, ST_NONE, SL_ALW);
        step("rl_rdw", 1'b0, 1'b0, 4'd3, ST_REQ, SL_MEM);
        rst = 1'b1;
        step("rl_rst", 1'b1, 1'b0, 4'd3, ST_NONE, SL_DEF);
        rst = 1'b0;

        // lw with two wait cycles on fetch and read
        step("lw_f0", 1'b0, 1'b0, 4'd0, ST_REQ, SL_DEF);
        step("lw_f1", 1'b0, 1'b0, 4'd0, ST_REQ, SL_DEF);
        step("lw_f2", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("lw_dec", 1'b1, 1'b0, 4'd1, ST_NONE, SL_DEC);
        step("lw_adr", 1'b0, 1'b0, 4'd2, ST_NONE, SL_ALW);
        step("lw_r0", 1'b0, 1'b0, 4'd3, ST_REQ, SL_MEM);
        step("lw_r1", 1'b0, 1'b0, 4'd3, ST_REQ, SL_MEM);
        step("lw_r2", 1'b1, 1'b0, 4'd3, ST_REQ, SL_MEM);
        step("lw_wb", 1'b0, 1'b0, 4'd4, ST_WB, SL_MWB);

        // R-type sweep
        op = OP_R;
        for (int i = 0; i < 4; i++) begin
            func3 = r_f3[i];
            func7 = r_f7[i];
            step("r_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
            step("r_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
            step("r_ex", 1'b0, 1'b0, 4'd6, ST_NONE, sl_ex(r_alu[i]));
            step("r_wb", 1'b0, 1'b0, 4'd7, ST_WB, SL_DEF);
        end

        // beq taken and not taken
        op = OP_BEQ;
        step("bt_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("bt_dec", 1'b0, 1'b1, 4'd1, ST_NONE, SL_DEC);
        step("bt_beq", 1'b0, 1'b1, 4'd8, ST_BEQT, SL_BEQ);
        step("bn_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("bn_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
        step("bn_beq", 1'b0, 1'b0, 4'd8, ST_BEQN, SL_BEQ);

        // R-type with unsupported func3
        op    = OP_R;
        func3 = 3'b001;
        func7 = 7'h00;
        step("rx_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("rx_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
        step("rx_ex", 1'b0, 1'b0, 4'd6, ST_NONE, sl_ex(3'b111));
        step("rx_ill", 1'b1, 1'b0, 4'd15, ST_ILL, SL_DEF);
        rst = 1'b1;
        step("rx_rst", 1'b0, 1'b0, 4'd15, ST_NONE, SL_DEF);
        rst = 1'b0;

        // unsupported opcode, then sticky trap
        op = OP_IMM;
        step("io_fetch", 1'b1, 1'b0, 4'd0, ST_FRDY, SL_FRDY);
        step("io_dec", 1'b0, 1'b0, 4'd1, ST_NONE, SL_DEC);
        for (int i = 0; i < 20; i++) begin
            step("io_ill", i[0], 1'b1, 4'd15, ST_ILL, SL_DEF);
        end
        rst = 1'b1;
        step("io_rst", 1'b1, 1'b0, 4'd15, ST_NONE, SL_DEF);
        rst = 1'b0;
        step("io_after", 1'b0, 1'b0, 4'd0, ST_REQ, SL_DEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
